// File: rtl/classifier_pkg.sv
// Shared constants and enumerations for the cascade-classifier rectangle address path.
package classifier_pkg;

  localparam int W_RECT      = 5;
  localparam int W_RECT_ADDR = 14;
  localparam int W_ADDR      = 10;
  localparam int WIN_W       = 25;

  typedef enum logic [1:0] {FLD_X, FLD_Y, FLD_W, FLD_H} rect_field_t;

  typedef enum logic [1:0] {CRN_A, CRN_B, CRN_C, CRN_D} corner_t;

  typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_CALC, ST_EMIT} gen_state_t;

endpackage

// File: rtl/rect_corner_calc.sv
// Combinational conversion of one rectangle (x,y,w,h) into its four integral-image
// corner addresses plus a flag for rectangles that leave the 24x24 window.
import classifier_pkg::*;

module rect_corner_calc (
  input  logic [W_RECT-1:0] x_i,
  input  logic [W_RECT-1:0] y_i,
  input  logic [W_RECT-1:0] w_i,
  input  logic [W_RECT-1:0] h_i,
  output logic [W_ADDR-1:0] a_o,
  output logic [W_ADDR-1:0] b_o,
  output logic [W_ADDR-1:0] c_o,
  output logic [W_ADDR-1:0] d_o,
  output logic              oob_o
);

  localparam int CW = W_ADDR + 2;
  localparam logic [W_RECT:0] LIMIT = (W_RECT + 1)'(WIN_W - 1);

  logic [CW-1:0]   x_e;
  logic [CW-1:0]   w_e;
  logic [CW-1:0]   row_top;
  logic [CW-1:0]   row_bot;
  logic [W_RECT:0] right_edge;
  logic [W_RECT:0] bottom_edge;

  assign x_e     = CW'(x_i);
  assign w_e     = CW'(w_i);
  assign row_top = CW'(y_i) * CW'(WIN_W);
  assign row_bot = (CW'(y_i) + CW'(h_i)) * CW'(WIN_W);

  // Sums are formed at full internal width and only truncated at the port.
  assign a_o = W_ADDR'(row_top + x_e);
  assign b_o = W_ADDR'(row_top + x_e + w_e);
  assign c_o = W_ADDR'(row_bot + x_e);
  assign d_o = W_ADDR'(row_bot + x_e + w_e);

  assign right_edge  = {1'b0, x_i} + {1'b0, w_i};
  assign bottom_edge = {1'b0, y_i} + {1'b0, h_i};
  assign oob_o       = (right_edge > LIMIT) || (bottom_edge > LIMIT);

endmodule

// File: rtl/rect_addr_gen.sv
// Walks the rect memory one field read at a time and streams the A,B,C,D corner
// addresses of every rectangle to the integral-image window read port.
import classifier_pkg::*;

module rect_addr_gen #(
  parameter int N_RECT = 2913
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  output logic                   busy_o,
  output logic                   err_o,
  output logic                   mem_addr_valid_o,
  input  logic                   mem_addr_ready_i,
  output logic [W_RECT_ADDR-1:0] mem_addr_data_o,
  input  logic                   mem_data_valid_i,
  output logic                   mem_data_ready_o,
  input  logic [W_RECT-1:0]      mem_data_i,
  output logic                   addr_valid_o,
  input  logic                   addr_ready_i,
  output logic [W_ADDR-1:0]      addr_data_o,
  output logic [1:0]             addr_corner_o,
  output logic                   addr_last_o
);

  localparam int W_R = W_RECT_ADDR - 2;
  localparam logic [W_R-1:0] LAST_R = W_R'(N_RECT - 1);

  gen_state_t  state_q, state_d;
  logic [W_R-1:0] r_q, r_d;
  rect_field_t k_q, k_d;
  corner_t     crn_q, crn_d;
  logic        err_q, err_d;

  logic [W_RECT-1:0] fld_q [4];
  logic [W_ADDR-1:0] cr_q  [4];
  logic [W_ADDR-1:0] calc_a, calc_b, calc_c, calc_d;
  logic              calc_oob;

  rect_corner_calc u_calc (
    .x_i   (fld_q[FLD_X]),
    .y_i   (fld_q[FLD_Y]),
    .w_i   (fld_q[FLD_W]),
    .h_i   (fld_q[FLD_H]),
    .a_o   (calc_a),
    .b_o   (calc_b),
    .c_o   (calc_c),
    .d_o   (calc_d),
    .oob_o (calc_oob)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      r_q     <= '0;
      k_q     <= FLD_X;
      crn_q   <= CRN_A;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      k_q     <= k_d;
      crn_q   <= crn_d;
      err_q   <= err_d;
    end
  end

  // Only one field read is ever in flight: REQ issues it, WAIT collects it.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    k_d     = k_q;
    crn_d   = crn_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_REQ;
          r_d     = '0;
          k_d     = FLD_X;
          err_d   = 1'b0;
        end
      end
      ST_REQ: begin
        if (mem_addr_ready_i) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_data_valid_i) begin
          if (k_q == FLD_H) begin
            state_d = ST_CALC;
          end else begin
            k_d     = rect_field_t'(k_q + 2'd1);
            state_d = ST_REQ;
          end
        end
      end
      ST_CALC: begin
        state_d = ST_EMIT;
        crn_d   = CRN_A;
        if (calc_oob) err_d = 1'b1;
      end
      ST_EMIT: begin
        if (addr_ready_i) begin
          if (crn_q == CRN_D) begin
            k_d = FLD_X;
            if (r_q == LAST_R) begin
              state_d = ST_IDLE;
              r_d     = '0;
            end else begin
              state_d = ST_REQ;
              r_d     = r_q + W_R'(1);
            end
          end else begin
            crn_d = corner_t'(crn_q + 2'd1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) fld_q[i] <= '0;
    end else if (state_q == ST_WAIT && mem_data_valid_i) begin
      fld_q[k_q] <= mem_data_i;
    end
  end

  // Corners are frozen in CALC so addr_data stays stable however long EMIT stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) cr_q[i] <= '0;
    end else if (state_q == ST_CALC) begin
      cr_q[CRN_A] <= calc_a;
      cr_q[CRN_B] <= calc_b;
      cr_q[CRN_C] <= calc_c;
      cr_q[CRN_D] <= calc_d;
    end
  end

  assign busy_o           = (state_q != ST_IDLE);
  assign err_o            = err_q;
  assign mem_addr_valid_o = (state_q == ST_REQ);
  assign mem_addr_data_o  = {r_q, k_q};
  assign mem_data_ready_o = (state_q == ST_WAIT);
  assign addr_valid_o     = (state_q == ST_EMIT);
  assign addr_data_o      = cr_q[crn_q];
  assign addr_corner_o    = crn_q;
  assign addr_last_o      = (state_q == ST_EMIT) && (crn_q == CRN_D) && (r_q == LAST_R);

endmodule

// File: tb/tb_rect_addr_gen.sv
// Scoreboard bench for rect_addr_gen: a latency-randomising rect memory model and a
// stalling corner sink compare the DUT streams against a reference corner model.
import classifier_pkg::*;

module tb_rect_addr_gen;

  localparam int NR = 3;

  typedef struct {
    logic [W_ADDR-1:0] data;
    logic [1:0]        corner;
    logic              last;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start;
  logic                   busy, err;
  logic                   memAddrValid, memAddrReady;
  logic [W_RECT_ADDR-1:0] memAddrData;
  logic                   memDataValid, memDataReady;
  logic [W_RECT-1:0]      memData;
  logic                   addrValid, addrReady;
  logic [W_ADDR-1:0]      addrData;
  logic [1:0]             addrCorner;
  logic                   addrLast;

  logic [W_RECT-1:0]      mem [4*NR];
  exp_t                   expQ[$];
  int                     memAddrQ[$];
  exp_t                   sinkExp;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int hCycle     = -100;
  int outCount   = 0;
  int stallLeft  = 0;
  int lat        = 0;
  bit rndMode    = 0;
  bit pending    = 0;
  bit addrFireM  = 0;
  bit dataFireM  = 0;
  bit prevValid  = 0;
  logic [W_RECT_ADDR-1:0] pendAddr = '0;

  rect_addr_gen #(.N_RECT(NR)) dut (
    .clk              (clk),
    .rst              (rst),
    .start_i          (start),
    .busy_o           (busy),
    .err_o            (err),
    .mem_addr_valid_o (memAddrValid),
    .mem_addr_ready_i (memAddrReady),
    .mem_addr_data_o  (memAddrData),
    .mem_data_valid_i (memDataValid),
    .mem_data_ready_o (memDataReady),
    .mem_data_i       (memData),
    .addr_valid_o     (addrValid),
    .addr_ready_i     (addrReady),
    .addr_data_o      (addrData),
    .addr_corner_o    (addrCorner),
    .addr_last_o      (addrLast)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expV);
    compared++;
    assert (obs === expV) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expV);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic loadRect(input int r, input int x, input int y, input int w, input int h);
    mem[4*r+0] = W_RECT'(x);
    mem[4*r+1] = W_RECT'(y);
    mem[4*r+2] = W_RECT'(w);
    mem[4*r+3] = W_RECT'(h);
  endtask

  // Reference corner model evaluated from the memory image at the time of start.
  task automatic pushPass();
    int x, y, w, h;
    int crn [4];
    exp_t e;
    for (int r = 0; r < NR; r++) begin
      x = int'(mem[4*r+0]);
      y = int'(mem[4*r+1]);
      w = int'(mem[4*r+2]);
      h = int'(mem[4*r+3]);
      crn[0] = y * WIN_W + x;
      crn[1] = y * WIN_W + x + w;
      crn[2] = (y + h) * WIN_W + x;
      crn[3] = (y + h) * WIN_W + x + w;
      for (int k = 0; k < 4; k++) begin
        memAddrQ.push_back(4*r + k);
        e.data   = W_ADDR'(crn[k]);
        e.corner = 2'(k);
        e.last   = (r == NR-1) && (k == 3);
        expQ.push_back(e);
      end
    end
  endtask

  task automatic applyStimulus();
    pushPass();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic waitDone(input string tag);
    int n = 0;
    while ((busy || expQ.size() != 0) && n < 2000) begin
      tick();
      n++;
    end
    checkOutput({tag, "Timeout"}, 32'(n >= 2000), 0);
    if (n >= 2000) begin
      expQ.delete();
      memAddrQ.delete();
    end
    checkOutput({tag, "BusyLow"}, busy, 0);
  endtask

  // Rect memory: one request at a time, response after 0..7 idle cycles in random mode.
  always @(negedge clk) begin
    if (rst) begin
      pending      = 0;
      memDataValid = 1'b0;
      memData      = '0;
      memAddrReady = 1'b1;
      addrFireM    = 0;
      dataFireM    = 0;
    end else begin
      if (dataFireM) begin
        memDataValid = 1'b0;
        pending      = 0;
      end
      if (addrFireM) begin
        pending = 1;
        lat     = rndMode ? int'($urandom_range(0, 7)) : 0;
      end
      if (pending && !memDataValid) begin
        if (lat == 0) begin
          memDataValid = 1'b1;
          memData      = mem[pendAddr];
        end else begin
          lat--;
        end
      end
      memAddrReady = rndMode ? 1'($urandom_range(0, 1)) : 1'b1;
      addrFireM = memAddrValid && memAddrReady;
      if (addrFireM) begin
        checkOutput("oneOutstanding", 32'(pending), 0);
        checkOutput("memAddrExpected", 32'(memAddrQ.size() != 0), 1);
        if (memAddrQ.size() != 0) checkOutput("memAddr", memAddrData, memAddrQ.pop_front());
        pendAddr = memAddrData;
      end
      dataFireM = memDataValid && memDataReady;
      if (dataFireM && pendAddr[1:0] == 2'd3) hCycle = cyc;
    end
  end

  // Corner sink: optional B stall, random back-pressure, scoreboard pop on handshake.
  always @(negedge clk) begin
    if (rst) begin
      addrReady = 1'b1;
      prevValid = 0;
    end else begin
      if (addrValid && !prevValid) checkOutput("emitLatency", cyc - hCycle, 2);
      prevValid = addrValid;
      if (addrValid && addrCorner == 2'd1 && stallLeft > 0 && expQ.size() != 0) begin
        addrReady = 1'b0;
        stallLeft--;
        checkOutput("stallHoldB", addrData, expQ[0].data);
      end else begin
        addrReady = rndMode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (addrValid && addrReady) begin
        checkOutput("cornerExpected", 32'(expQ.size() != 0), 1);
        if (expQ.size() != 0) begin
          sinkExp = expQ.pop_front();
          checkOutput("addrData", addrData, sinkExp.data);
          checkOutput("addrCorner", addrCorner, sinkExp.corner);
          checkOutput("addrLast", addrLast, sinkExp.last);
        end
        outCount++;
      end
    end
  end

  initial begin
    int base;
    int n;
    rst   = 1'b1;
    start = 1'b0;
    loadRect(0, 2, 3, 4, 5);
    loadRect(1, 1, 0, 3, 2);
    loadRect(2, 10, 12, 6, 7);
    repeat (3) tick();

    checkOutput("rstBusy", busy, 0);
    checkOutput("rstErr", err, 0);
    checkOutput("rstMemAddrValid", memAddrValid, 0);
    checkOutput("rstMemDataReady", memDataReady, 0);
    checkOutput("rstAddrValid", addrValid, 0);
    checkOutput("rstAddrLast", addrLast, 0);
    checkOutput("rstAddrData", addrData, 0);
    checkOutput("rstAddrCorner", addrCorner, 0);
    checkOutput("rstMemAddrData", memAddrData, 0);
    rst = 1'b0;
    tick();

    // Basic pass (77,81,202,206 first) with B held off for five cycles.
    stallLeft = 5;
    applyStimulus();
    waitDone("pass1");
    checkOutput("pass1Err", err, 0);
    checkOutput("pass1StallUsed", stallLeft, 0);

    // Random memory latency and toggling ready on both ports.
    rndMode = 1;
    applyStimulus();
    waitDone("passRnd");
    rndMode = 0;
    repeat (2) tick();

    // A second start while busy must not launch another pass.
    base = outCount;
    applyStimulus();
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    waitDone("passStart");
    repeat (20) tick();
    checkOutput("singlePassCount", outCount - base, 4*NR);
    checkOutput("singlePassIdle", busy, 0);

    // Out-of-window rect: corners 20,30,45,55 still emitted, err sticky until next start.
    loadRect(1, 20, 0, 10, 1);
    applyStimulus();
    waitDone("passOob");
    checkOutput("oobErrSet", err, 1);
    repeat (5) tick();
    checkOutput("oobErrSticky", err, 1);
    loadRect(1, 1, 0, 3, 2);
    applyStimulus();
    checkOutput("startClearsErr", err, 0);
    waitDone("passClean");
    checkOutput("cleanErr", err, 0);

    // Reset in EMIT right after corner A of rect 0 is accepted.
    base = outCount;
    applyStimulus();
    n = 0;
    while (outCount == base && n < 500) begin
      tick();
      n++;
    end
    checkOutput("reachA", outCount - base, 1);
    rst = 1'b1;
    tick();
    checkOutput("midRstBusy", busy, 0);
    checkOutput("midRstAddrValid", addrValid, 0);
    checkOutput("midRstMemAddrValid", memAddrValid, 0);
    checkOutput("midRstMemDataReady", memDataReady, 0);
    rst = 1'b0;
    expQ.delete();
    memAddrQ.delete();
    repeat (10) tick();
    checkOutput("noPartialCorners", outCount - base, 1);
    applyStimulus();
    checkOutput("restartMemValid", memAddrValid, 1);
    checkOutput("restartMemAddr", memAddrData, 0);
    waitDone("passRestart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
